// File: rtl/io_pwm_pkg.sv
// Shared register offsets, control bit positions and address decode for io_pwm_bank.
package io_pwm_pkg;

  localparam logic [4:0] OFF_DUTY  = 5'h00;
  localparam logic [4:0] OFF_CTRL  = 5'h10;
  localparam logic [4:0] OFF_PRESC = 5'h11;
  localparam logic [4:0] OFF_COUNT = 5'h12;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_INV_BIT = 1;

  // The register window is 32 bytes on a 32-byte boundary.
  function automatic logic in_window(input logic [15:0] a, input logic [15:0] base);
    return (a & 16'hFFE0) == (base & 16'hFFE0);
  endfunction

endpackage

// File: rtl/io_pwm_bank_timebase.sv
// PWM timebase: prescaler that ticks every PRESC+1 clocks and the free-running PWM counter.
module pwm_timebase #(
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned PWM_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PRESC_W-1:0] presc,
  output logic [PWM_W-1:0]   pwm_ctr,
  output logic               tick,
  output logic               wrap
);

  logic [PRESC_W-1:0] presc_ctr_q, presc_ctr_d;
  logic [PWM_W-1:0]   pwm_ctr_q, pwm_ctr_d;

  assign tick    = (presc_ctr_q == presc);
  // Terminal count; the caller qualifies it with tick to find the wrapping edge.
  assign wrap    = (pwm_ctr_q == {PWM_W{1'b1}});
  assign pwm_ctr = pwm_ctr_q;

  // A prescaler lowered below the running count free-runs through its full range.
  always_comb begin
    presc_ctr_d = presc_ctr_q + PRESC_W'(1);
    pwm_ctr_d   = pwm_ctr_q;
    if (tick) begin
      presc_ctr_d = '0;
      pwm_ctr_d   = pwm_ctr_q + PWM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_ctr_q <= '0;
      pwm_ctr_q   <= '0;
    end else begin
      presc_ctr_q <= presc_ctr_d;
      pwm_ctr_q   <= pwm_ctr_d;
    end
  end

endmodule

// File: rtl/io_pwm_bank.sv
// Memory-mapped PWM bank on the 65C02 bus: duty/control registers, read mux, PWM outputs.
// Define IO_PWM_SHADOW_EN to double-buffer DUTY writes until the next period wrap.
module io_pwm_bank
  import io_pwm_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       addr,
  input  logic [7:0]        data_in,
  input  logic              write_enable,
  output logic [7:0]        data_out,
  output logic              sel,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  logic [PWM_W-1:0]   duty_act_q [NUM_CH];
  logic [PWM_W-1:0]   duty_act_d [NUM_CH];
  logic [PWM_W-1:0]   duty_rd    [NUM_CH];
  logic               en_q, en_d;
  logic               inv_q, inv_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               sel_q, sel_d;
  logic [NUM_CH-1:0]  pwm_out_q, pwm_out_d;
  logic               period_start_q, period_start_d;

  logic [PWM_W-1:0]   pwm_ctr;
  logic               tick, wrap, load;
  logic               hit, wr;
  logic [4:0]         off;

  assign hit  = in_window(addr, BASE_ADDR);
  assign off  = addr[4:0];
  assign wr   = hit & write_enable;
  assign load = tick & wrap;

  pwm_timebase #(
    .PRESC_W (PRESC_W),
    .PWM_W   (PWM_W)
  ) u_timebase (
    .clk     (clk),
    .reset_n (reset_n),
    .presc   (presc_q),
    .pwm_ctr (pwm_ctr),
    .tick    (tick),
    .wrap    (wrap)
  );

  always_comb begin
    en_d    = en_q;
    inv_d   = inv_q;
    presc_d = presc_q;
    if (wr && off == OFF_CTRL) begin
      en_d  = data_in[CTRL_EN_BIT];
      inv_d = data_in[CTRL_INV_BIT];
    end
    if (wr && off == OFF_PRESC) begin
      presc_d = PRESC_W'(data_in);
    end
  end

`ifdef IO_PWM_SHADOW_EN
  logic [PWM_W-1:0] duty_shd_q [NUM_CH];
  logic [PWM_W-1:0] duty_shd_d [NUM_CH];

  assign duty_rd = duty_shd_q;

  // The active copy takes the shadow as it stood before any same-cycle write.
  always_comb begin
    duty_act_d = duty_act_q;
    duty_shd_d = duty_shd_q;
    if (load) begin
      duty_act_d = duty_shd_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && off == OFF_DUTY + 5'(i)) begin
        duty_shd_d[i] = data_in[PWM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_shd_q[i] <= '0;
      end
    end else begin
      duty_shd_q <= duty_shd_d;
    end
  end
`else
  assign duty_rd = duty_act_q;

  always_comb begin
    duty_act_d = duty_act_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && off == OFF_DUTY + 5'(i)) begin
        duty_act_d[i] = data_in[PWM_W-1:0];
      end
    end
  end
`endif

  // Read data reflects register state before any write committed on the same edge.
  always_comb begin
    data_out_d = 8'h00;
    if (hit) begin
      case (off)
        OFF_CTRL: begin
          data_out_d[CTRL_EN_BIT]  = en_q;
          data_out_d[CTRL_INV_BIT] = inv_q;
        end
        OFF_PRESC: data_out_d = 8'(presc_q);
        OFF_COUNT: data_out_d = 8'(pwm_ctr);
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (off == OFF_DUTY + 5'(i)) begin
              data_out_d = 8'(duty_rd[i]);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_out_d[i] = (en_q & (pwm_ctr < duty_act_q[i])) ^ inv_q;
    end
    sel_d          = hit;
    period_start_d = load;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act_q[i] <= '0;
      end
      en_q           <= 1'b0;
      inv_q          <= 1'b0;
      presc_q        <= '0;
      data_out_q     <= 8'h00;
      sel_q          <= 1'b0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_act_q     <= duty_act_d;
      en_q           <= en_d;
      inv_q          <= inv_d;
      presc_q        <= presc_d;
      data_out_q     <= data_out_d;
      sel_q          <= sel_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign data_out     = data_out_q;
  assign sel          = sel_q;
  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_io_pwm_bank.sv
// Self-checking bench for io_pwm_bank: directed steps plus random bus traffic vs a reference model.
module tb_io_pwm_bank;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int NCH = 3;
`ifdef IO_PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        write_enable;
  logic [7:0]  data_out;
  logic        sel;
  logic [2:0]  pwm_out;
  logic        period_start;

  always #5 clk = ~clk;

  io_pwm_bank #(
    .BASE_ADDR (BASE),
    .NUM_CH    (NCH),
    .PWM_W     (8),
    .PRESC_W   (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out),
    .sel          (sel),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents, total ticks seen, and prescaler phase.
  int m_act[NCH];
  int m_shd[NCH];
  int m_en, m_inv, m_presc, m_pc, m_ticks;
  logic [7:0] e_dout;
  logic       e_sel;
  logic [2:0] e_pwm;
  logic       e_ps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 0;
      m_shd[i] = 0;
    end
    m_en = 0; m_inv = 0; m_presc = 0; m_pc = 0; m_ticks = 0;
    e_dout = 8'h00; e_sel = 1'b0; e_pwm = 3'b000; e_ps = 1'b0;
  endtask

  function automatic int m_read(input int off);
    if (off < NCH) return SHADOW ? m_shd[off] : m_act[off];
    if (off == 16) return m_inv * 2 + m_en;
    if (off == 17) return m_presc;
    if (off == 18) return m_ticks % 256;
    return 0;
  endfunction

  task automatic model_edge(input logic [15:0] a, input logic [7:0] d, input logic we);
    bit hit;
    int off;
    int cnt;
    bit tk;
    bit wraps;
    hit   = (a >= BASE) && (a < BASE + 16'd32);
    off   = int'(a) - int'(BASE);
    cnt   = m_ticks % 256;
    e_dout = hit ? 8'(m_read(off)) : 8'h00;
    e_sel  = hit;
    for (int i = 0; i < NCH; i++) begin
      e_pwm[i] = ((m_en != 0) && (cnt < m_act[i])) ^ (m_inv != 0);
    end
    tk    = (m_pc == m_presc);
    wraps = tk && (cnt == 255);
    e_ps  = wraps;
    if (tk) begin
      m_pc = 0;
      m_ticks++;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
    if (SHADOW && wraps) begin
      for (int i = 0; i < NCH; i++) m_act[i] = m_shd[i];
    end
    if (hit && we) begin
      if (off < NCH) begin
        if (SHADOW) m_shd[off] = int'(d);
        else m_act[off] = int'(d);
      end else if (off == 16) begin
        m_en  = int'(d[0]);
        m_inv = int'(d[1]);
      end else if (off == 17) begin
        m_presc = int'(d);
      end
    end
  endtask

  // One clock: model follows the edge, then every output is compared #1 later.
  task automatic cyc();
    @(posedge clk);
    model_edge(addr, data_in, write_enable);
    #1;
    chk("cycle", {19'd0, data_out, sel, pwm_out, period_start},
        {19'd0, e_dout, e_sel, e_pwm, e_ps});
  endtask

  task automatic wr(input logic [4:0] off, input logic [7:0] val);
    addr = BASE + 16'(off); data_in = val; write_enable = 1'b1;
    cyc();
    write_enable = 1'b0; addr = 16'h0000; data_in = 8'h00;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr = a; write_enable = 1'b0;
    cyc();
    chk(tag, {24'd0, data_out}, {24'd0, exp});
    addr = 16'h0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int hi0, hi1, hi2, ps_cnt, gap;
    bit found;
    logic [7:0] v[9];
    logic [4:0] roff;

    reset_n = 1'b0; addr = 16'h0000; data_in = 8'h00; write_enable = 1'b0;
    model_reset();
    #22 reset_n = 1'b1;
    rd("count_after_reset", BASE + 16'h12, 8'h00);

    // DUTY0=0x40, DUTY1=0, DUTY2=0xFF, tick every clock, enabled.
    wr(5'h00, 8'h40); wr(5'h01, 8'h00); wr(5'h02, 8'hFF);
    wr(5'h11, 8'h00); wr(5'h10, 8'h01);
    idle(3);
    hi0 = 0; hi1 = 0; hi2 = 0; ps_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
      ps_cnt += int'(period_start);
    end
    chk("ch0_high_64", hi0, 64);
    chk("ch1_never_high", hi1, 0);
    chk("ch2_low_once", hi2, 255);
    chk("period_start_256", ps_cnt, 1);

    wr(5'h10, 8'h03);
    idle(3);
    hi0 = 0; hi1 = 0; hi2 = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
    end
    chk("inv_ch0", hi0, 192);
    chk("inv_ch1", hi1, 256);
    chk("inv_ch2", hi2, 1);

    // PRESC=3: four clocks per count, 1024 clocks per period.
    wr(5'h10, 8'h01); wr(5'h11, 8'h03);
    addr = BASE + 16'h12;
    for (int i = 0; i < 9; i++) begin
      cyc();
      v[i] = data_out;
    end
    addr = 16'h0000;
    chk("count_step_4clk", {24'd0, 8'(v[4] - v[0])}, 32'd1);
    chk("count_step_8clk", {24'd0, 8'(v[8] - v[0])}, 32'd2);
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      cyc();
      found = period_start;
    end
    chk("first_wrap_seen", {31'd0, found}, 32'd1);
    gap = 0; found = 1'b0; hi0 = 0;
    while (!found && gap < 1100) begin
      cyc();
      gap++;
      found = period_start;
      hi0 += int'(pwm_out[0]);
    end
    chk("period_1024", gap, 1024);
    chk("ch0_high_presc", hi0, 256);

    // Lowering PRESC below the running prescaler count must not lock up.
    wr(5'h11, 8'd200); idle(40); wr(5'h11, 8'd10); idle(300); wr(5'h11, 8'h00);

    // Register map readback.
    wr(5'h10, 8'hFF);
    rd("ctrl_readback", BASE + 16'h10, 8'h03);
    rd("presc_readback", BASE + 16'h11, 8'h00);
    rd("duty0_readback", BASE + 16'h00, 8'h40);
    rd("offset_1f", BASE + 16'h1F, 8'h00);
    chk("sel_in_window", {31'd0, sel}, 32'd1);
    rd("outside_window", 16'h1234, 8'h00);
    chk("sel_outside", {31'd0, sel}, 32'd0);
    rd("just_below_window", BASE - 16'd1, 8'h00);
    wr(5'h12, 8'h77);

    // Random bus traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      roff = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) < 85) addr = BASE + 16'(roff);
      else addr = 16'($urandom);
      write_enable = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
      if (addr == BASE + 16'h11) data_in = 8'($urandom_range(0, 3));
      cyc();
    end
    write_enable = 1'b0; addr = 16'h0000;

`ifdef IO_PWM_SHADOW_EN
    // Write landing on the exact wrap edge takes effect one period later.
    wr(5'h11, 8'h00); wr(5'h10, 8'h01); wr(5'h00, 8'h10);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      cyc();
      found = period_start;
    end
    chk("shadow_sync", {31'd0, found}, 32'd1);
    wr(5'h00, 8'h80);
    idle(254);
    wr(5'h00, 8'hC0);
    chk("shadow_wrap_edge", {31'd0, period_start}, 32'd1);
    hi0 = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      hi0 += int'(pwm_out[0]);
    end
    chk("shadow_old_applied", hi0, 128);
`endif

    // Asynchronous reset mid-period with nonzero outputs.
    wr(5'h10, 8'h03);
    addr = BASE + 16'h10;
    idle(5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {19'd0, data_out, sel, pwm_out, period_start}, 32'd0);
    model_reset();
    addr = 16'h0000;
    #10 reset_n = 1'b1;
    rd("count_after_midrun_reset", BASE + 16'h12, 8'h00);
    rd("ctrl_after_reset", BASE + 16'h10, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
